// File: rtl/sarlock_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sarlock_pipe
//  Purpose  : Two-stage pipelined W-bit adder locked by a serially loaded key.
//             With the correct key (SECRET) every sum is exact. With any other
//             key, the single input pattern equal to that key has output bit
//             FLIP_BIT inverted.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             key_load_start     - pulse: restart key load, flush pipeline
//             key_shift_en       - shift key_bit into key register (LOAD only)
//             key_bit            - serial key data, MSB first
//             key_ok             - full key loaded (FSM in READY)
//             in_valid/in_ready  - input handshake, inputs = {b, a}
//             out_valid/out_ready- output handshake, out_data = locked sum
//  Revision : 1.0 - initial release
// ============================================================================
module sarlock_pipe #(
    parameter int               W        = 4,
    parameter logic [2*W-1:0]   SECRET   = 8'h6D,
    parameter int               FLIP_BIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load_start,
    input  logic                key_shift_en,
    input  logic                key_bit,
    output logic                key_ok,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*W-1:0]      inputs,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W:0]          out_data
);

    localparam int               c_kw       = 2 * W;
    localparam int               c_cw       = $clog2(c_kw + 1);
    localparam logic [c_cw-1:0]  c_cnt_full = c_cw'(c_kw);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [c_kw-1:0]   key_q,      key_d;
    logic [c_cw-1:0]   cnt_q,      cnt_d;

    logic              s1_valid_q, s1_valid_d;
    logic [W-1:0]      s1_a_q,     s1_a_d;
    logic [W-1:0]      s1_b_q,     s1_b_d;
    logic              s1_hit_q,   s1_hit_d;
    logic              s2_valid_q, s2_valid_d;
    logic [W:0]        s2_data_q,  s2_data_d;

    logic              s2_adv;
    logic              s1_free;
    logic              in_fire;
    logic [W:0]        sum;
    logic [W:0]        flip_mask;

    // ------------------------------------------------------------------
    // Key-load control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        if (key_load_start) begin
            // A start always wins, even over a coincident shift.
            state_d = LOAD;
            key_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (cnt_q == c_cnt_full) begin
                        state_d = READY;
                    end else if (key_shift_en) begin
                        key_d = {key_q[c_kw-2:0], key_bit};
                        cnt_d = cnt_q + c_cw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_ok = (state_q == READY);

    // ------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------
    // Stage 2 can take new data when empty or when its item leaves now;
    // stage 1 likewise when empty or when it moves into stage 2.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_free  = !s1_valid_q || s2_adv;
    assign in_ready = (state_q == READY) && s1_free;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        sum                 = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        flip_mask           = '0;
        flip_mask[FLIP_BIT] = s1_hit_q;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_hit_d   = s1_hit_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (key_load_start) begin
            // Flush: anything in flight, including a same-cycle transfer,
            // is dropped.
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_d = sum ^ flip_mask;
                end
            end
            if (s1_free) begin
                s1_valid_d = in_fire;
                if (in_fire) begin
                    s1_a_d   = inputs[W-1:0];
                    s1_b_d   = inputs[2*W-1:W];
                    // The SECRET term keeps the correct key from ever
                    // corrupting an output.
                    s1_hit_d = (inputs == key_q) && (inputs != SECRET);
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_hit_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_hit_q   <= s1_hit_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule
`default_nettype wire
